// File: rtl/x2p_pkg.sv
// -----------------------------------------------------------------------------
// x2p_pkg
//   Shared definitions for the X2P bridge APB master:
//   - x2p_state_e : FSM state encoding (IDLE/SETUP/ACCESS/RESP)
//   - field offsets of the packed command and response words
//   - x2p_cmd_t / x2p_rsp_t : packed command/response layouts at the default
//     16-bit address / 32-bit data widths
//   - helper functions that compute offsets and counter widths for
//     non-default parameterisations
// -----------------------------------------------------------------------------
package x2p_pkg;

  // Default bus widths used by the packed struct layouts below.
  localparam int X2P_ADDR_W = 16;
  localparam int X2P_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } x2p_state_e;

  // Command word: {write, addr, wdata}
  localparam int CMD_WDATA_LSB = 0;
  localparam int CMD_ADDR_LSB  = X2P_DATA_W;
  localparam int CMD_WRITE_BIT = X2P_DATA_W + X2P_ADDR_W;

  // Response word: {slverr, rdata}
  localparam int RSP_RDATA_LSB  = 0;
  localparam int RSP_SLVERR_BIT = X2P_DATA_W;

  typedef struct packed {
    logic                  write;
    logic [X2P_ADDR_W-1:0] addr;
    logic [X2P_DATA_W-1:0] wdata;
  } x2p_cmd_t;

  typedef struct packed {
    logic                  slverr;
    logic [X2P_DATA_W-1:0] rdata;
  } x2p_rsp_t;

  // Offsets for an arbitrary parameterisation of the same layout.
  function automatic int cmd_write_bit(input int aw, input int dw);
    return aw + dw;
  endfunction

  function automatic int cmd_addr_lsb(input int dw);
    return dw;
  endfunction

  function automatic int rsp_slverr_bit(input int dw);
    return dw;
  endfunction

  // Width of the wait-state counter. A disabled timeout (0) still gets a
  // one-bit counter so the port list stays identical.
  function automatic int tmo_cnt_w(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// -----------------------------------------------------------------------------
// apb_timeout_cnt
//   Wait-state counter for one APB ACCESS phase.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     clr       : zero the counter (asserted the cycle before ACCESS starts)
//     inc       : count one ACCESS cycle in which the slave was not ready
//     expire    : high while the counter sits at TIMEOUT-1, i.e. the current
//                 not-ready ACCESS cycle is the last one allowed; constant 0
//                 when TIMEOUT = 0
// -----------------------------------------------------------------------------
module apb_timeout_cnt
  import x2p_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int CW = tmo_cnt_w(TIMEOUT);

  logic [CW-1:0] cnt;

  // NOTE: sequential state is assigned with <= only, so every flop samples
  // the pre-edge values regardless of statement order in the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      // With the timeout disabled this free-runs and wraps; expire ignores it.
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/x2p_apb_master.sv
// -----------------------------------------------------------------------------
// x2p_apb_master
//   Pops packed commands from the bridge command FIFO, runs one APB
//   SETUP/ACCESS transfer per command and pushes one packed response per
//   command into the response FIFO. A wait-state timeout ends any ACCESS
//   phase that lasts TIMEOUT cycles without PREADY.
//   Ports:
//     clk, rst            : clock, asynchronous active-high reset
//     cmd_empty, cmd_data : command FIFO read side (head is combinational)
//     cmd_rd              : command FIFO pop (combinational)
//     rsp_full            : response FIFO full flag
//     rsp_wr, rsp_data    : response FIFO push (combinational) and data
//     psel, penable, pwrite, paddr, pwdata : APB requester outputs
//     pready, pslverr, prdata              : APB completer inputs
//     busy                : FSM away from IDLE
//     timeout_err         : one-cycle pulse when a transfer timed out
// -----------------------------------------------------------------------------
module x2p_apb_master
  import x2p_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_empty,
  input  logic [ADDR_WIDTH+DATA_WIDTH:0] cmd_data,
  output logic                           cmd_rd,
  input  logic                           rsp_full,
  output logic                           rsp_wr,
  output logic [DATA_WIDTH:0]            rsp_data,
  output logic                           psel,
  output logic                           penable,
  output logic                           pwrite,
  output logic [ADDR_WIDTH-1:0]          paddr,
  output logic [DATA_WIDTH-1:0]          pwdata,
  input  logic                           pready,
  input  logic                           pslverr,
  input  logic [DATA_WIDTH-1:0]          prdata,
  output logic                           busy,
  output logic                           timeout_err
);

  localparam int WR_BIT   = cmd_write_bit(ADDR_WIDTH, DATA_WIDTH);
  localparam int ADDR_LSB = cmd_addr_lsb(DATA_WIDTH);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] SETUP  = ST_SETUP;
  localparam logic [1:0] ACCESS = ST_ACCESS;
  localparam logic [1:0] RESP   = ST_RESP;

  logic [1:0] state;
  logic       tmo_clr;
  logic       tmo_inc;
  logic       tmo_expire;

  // FIFO handshakes are combinational so a pop/push lands on the same edge
  // that moves the FSM. Gating with rst keeps both low while reset is held,
  // even if the command FIFO is non-empty at that moment.
  assign cmd_rd = (state == IDLE) & ~cmd_empty & ~rst;
  assign rsp_wr = (state == RESP) & ~rsp_full  & ~rst;

  // Clearing during SETUP means the counter reads 0 on the first ACCESS cycle.
  assign tmo_clr = (state == SETUP);
  assign tmo_inc = (state == ACCESS) & ~pready;

  apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmo_clr),
    .inc    (tmo_inc),
    .expire (tmo_expire)
  );

  // All APB outputs are registered and computed one cycle ahead, so they
  // change only on the edge that enters the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_data    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (!cmd_empty) begin
            pwrite  <= cmd_data[WR_BIT];
            paddr   <= cmd_data[ADDR_LSB +: ADDR_WIDTH];
            pwdata  <= cmd_data[DATA_WIDTH-1:0];
            psel    <= 1'b1;
            penable <= 1'b0;
            busy    <= 1'b1;
            state   <= SETUP;
          end
        end

        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end

        ACCESS: begin
          // pready is tested first so a completion in the final allowed
          // cycle is reported as a normal response, not a timeout.
          if (pready) begin
            rsp_data <= {pslverr, pwrite ? {DATA_WIDTH{1'b0}} : prdata};
            psel     <= 1'b0;
            penable  <= 1'b0;
            state    <= RESP;
          end else if (tmo_expire) begin
            rsp_data    <= {1'b1, {DATA_WIDTH{1'b0}}};
            timeout_err <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            state       <= RESP;
          end
        end

        RESP: begin
          // Hold the response until the FIFO accepts it; it is never dropped.
          if (!rsp_full) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_x2p_apb_master.sv
// -----------------------------------------------------------------------------
// tb_x2p_apb_master
//   Self-checking bench for x2p_apb_master (16-bit address, 32-bit data,
//   TIMEOUT = 16). A queue stands in for the command FIFO, an APB completer
//   model answers each transfer after a per-command number of wait states,
//   and expected responses/timings come from the transfer rules directly.
// -----------------------------------------------------------------------------
module tb_x2p_apb_master;

  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int TO   = 16;
  localparam int CMDW = 1 + AW + DW;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_empty;
  logic [CMDW-1:0] cmd_data;
  logic            cmd_rd;
  logic            rsp_full;
  logic            rsp_wr;
  logic [DW:0]     rsp_data;
  logic            psel, penable, pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic            pready, pslverr;
  logic [DW-1:0]   prdata;
  logic            busy, timeout_err;

  always #5 clk = ~clk;

  x2p_apb_master #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_empty   (cmd_empty),
    .cmd_data    (cmd_data),
    .cmd_rd      (cmd_rd),
    .rsp_full    (rsp_full),
    .rsp_wr      (rsp_wr),
    .rsp_data    (rsp_data),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .pready      (pready),
    .pslverr     (pslverr),
    .prdata      (prdata),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  // One command plus the completer behaviour to use for it.
  typedef struct {
    bit            write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;   // not-ready ACCESS cycles before pready
    logic [DW-1:0] rdata;
    bit            slverr;
  } txn_t;

  txn_t        cmd_q[$];
  txn_t        cur;
  logic [DW:0] exp_q[$];
  logic [DW:0] got_q[$];
  int          pop_cyc[$];
  int          push_cyc[$];
  int          acc_len[$];
  int          cyc;
  int          acc_cnt;
  bit          was_access;
  int          stable_err;
  int          stall_viol;
  int          to_pulses;
  int          full_remaining;

  int n_checks;
  int n_pass;

  // Reference response: a transfer that would need more than TO ACCESS cycles
  // is cut off with {1, 0}; otherwise slverr plus rdata (zero for writes).
  function automatic logic [DW:0] ref_rsp(input txn_t t);
    if (t.waits >= TO) return {1'b1, {DW{1'b0}}};
    return {t.slverr, t.write ? {DW{1'b0}} : t.rdata};
  endfunction

  function automatic int ref_acc_len(input txn_t t);
    return (t.waits < TO) ? t.waits + 1 : TO;
  endfunction

  function automatic txn_t mk_txn(input bit w, input logic [AW-1:0] a,
                                  input logic [DW-1:0] wd, input int wt,
                                  input logic [DW-1:0] rd, input bit se);
    txn_t t;
    t.write = w; t.addr = a; t.wdata = wd; t.waits = wt; t.rdata = rd; t.slverr = se;
    return t;
  endfunction

  function automatic txn_t rand_txn(input int wt);
    return mk_txn(1'($urandom), AW'($urandom), $urandom, wt, $urandom, 1'($urandom));
  endfunction

  task automatic clear_obs();
    exp_q.delete(); got_q.delete(); pop_cyc.delete(); push_cyc.delete();
    acc_len.delete();
    stable_err = 0; stall_viol = 0; to_pulses = 0; full_remaining = 0;
  endtask

  // Cycle engine: drives FIFO/APB inputs at each falling edge, samples DUT
  // outputs 1 time unit later and records what happened. Stops when the
  // command queue is drained and the DUT is idle, or (stop_acc) on the first
  // ACCESS cycle. hung stays set if the budget runs out first.
  task automatic run(input int budget, input bit stop_acc, output bit hung);
    bit in_acc;
    hung = 1'b1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      cyc++;
      in_acc = psel && penable;
      if (psel && (paddr !== cur.addr || pwrite !== cur.write || pwdata !== cur.wdata))
        stable_err++;
      if (was_access && !in_acc) begin
        acc_len.push_back(acc_cnt);
        was_access = 1'b0;
      end

      cmd_empty = (cmd_q.size() == 0);
      if (cmd_q.size() != 0) cmd_data = {cmd_q[0].write, cmd_q[0].addr, cmd_q[0].wdata};
      else                   cmd_data = CMDW'({$urandom, $urandom});

      if (in_acc) begin
        pready  = (acc_cnt == cur.waits);
        prdata  = pready ? cur.rdata  : $urandom;
        pslverr = pready ? cur.slverr : 1'($urandom);
        acc_cnt++;
        was_access = 1'b1;
      end else begin
        pready  = 1'($urandom);
        prdata  = $urandom;
        pslverr = 1'($urandom);
      end

      if (busy && !psel && full_remaining > 0) begin
        rsp_full = 1'b1;
        full_remaining--;
      end else begin
        rsp_full = 1'b0;
      end

      #1;
      if (rsp_full && (cmd_rd || psel || penable || rsp_wr)) stall_viol++;
      if (timeout_err) to_pulses++;
      if (cmd_rd) begin
        cur = cmd_q.pop_front();
        pop_cyc.push_back(cyc);
        exp_q.push_back(ref_rsp(cur));
        acc_cnt = 0;
      end
      if (rsp_wr) begin
        got_q.push_back(rsp_data);
        push_cyc.push_back(cyc);
      end
      if (stop_acc && in_acc) begin hung = 1'b0; break; end
      if (!stop_acc && cmd_q.size() == 0 && !busy && !cmd_rd) begin hung = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_empty = 1'b0;
    cmd_data = CMDW'({$urandom, $urandom});
    rsp_full = 1'b0;
    #2;
    n_checks++;
    if ({psel, penable, pwrite, busy, timeout_err} !== 5'b0)
      $display("FAIL reset_ctrl: got %b required 00000", {psel, penable, pwrite, busy, timeout_err});
    else n_pass++;
    n_checks++;
    if ({paddr, pwdata, rsp_data} !== '0)
      $display("FAIL reset_data: got %h required 0", {paddr, pwdata, rsp_data});
    else n_pass++;
    @(posedge clk); @(negedge clk); #1;
    n_checks++;
    if ({cmd_rd, rsp_wr, psel} !== 3'b0)
      $display("FAIL reset_handshake: got %b required 000", {cmd_rd, rsp_wr, psel});
    else n_pass++;
    cmd_empty = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    bit hung;
    clear_obs();
    cmd_q.push_back(mk_txn(1'b0, 16'h0010, $urandom, 0, 32'hDEADBEEF, 1'b0));
    run(50, 1'b0, hung);
    n_checks++;
    if (hung || got_q.size() != 1)
      $display("FAIL single_count: hung=%0d got %0d responses required 1", hung, got_q.size());
    else n_pass++;
    if (got_q.size() == 1) begin
      n_checks++;
      if (got_q[0] !== {1'b0, 32'hDEADBEEF})
        $display("FAIL single_rsp: got %h required %h", got_q[0], {1'b0, 32'hDEADBEEF});
      else n_pass++;
      n_checks++;
      if (push_cyc[0] - pop_cyc[0] != 3)
        $display("FAIL single_latency: push %0d cycles after pop, required 3", push_cyc[0] - pop_cyc[0]);
      else n_pass++;
    end
  endtask

  task automatic test_write_waits();
    bit hung;
    clear_obs();
    cmd_q.push_back(mk_txn(1'b1, 16'h0020, 32'h12345678, 3, $urandom, 1'b1));
    run(50, 1'b0, hung);
    n_checks++;
    if (hung || got_q.size() != 1 || acc_len.size() != 1)
      $display("FAIL write_count: hung=%0d got %0d responses required 1", hung, got_q.size());
    else n_pass++;
    if (got_q.size() == 1 && acc_len.size() == 1) begin
      n_checks++;
      if (got_q[0] !== {1'b1, 32'h0})
        $display("FAIL write_rsp: got %h required %h", got_q[0], {1'b1, 32'h0});
      else n_pass++;
      n_checks++;
      if (acc_len[0] != 4)
        $display("FAIL write_access_len: got %0d required 4", acc_len[0]);
      else n_pass++;
    end
    n_checks++;
    if (stable_err != 0)
      $display("FAIL write_stable: %0d unstable cycles, required 0", stable_err);
    else n_pass++;
  endtask

  task automatic test_timeout();
    bit hung;
    clear_obs();
    cmd_q.push_back(mk_txn(1'b0, AW'($urandom), $urandom, 100, $urandom, 1'b0));
    // Completes on the last allowed cycle: pready must beat the timeout.
    cmd_q.push_back(mk_txn(1'b0, AW'($urandom), $urandom, TO - 1, $urandom, 1'b0));
    run(100, 1'b0, hung);
    n_checks++;
    if (hung || got_q.size() != 2 || acc_len.size() != 2)
      $display("FAIL timeout_count: hung=%0d got %0d responses required 2", hung, got_q.size());
    else n_pass++;
    if (got_q.size() == 2 && acc_len.size() == 2) begin
      n_checks++;
      if (acc_len[0] != TO)
        $display("FAIL timeout_access_len: got %0d required %0d", acc_len[0], TO);
      else n_pass++;
      n_checks++;
      if (got_q[0] !== {1'b1, 32'h0})
        $display("FAIL timeout_rsp: got %h required %h", got_q[0], {1'b1, 32'h0});
      else n_pass++;
      n_checks++;
      if (got_q[1] !== exp_q[1] || acc_len[1] != TO)
        $display("FAIL timeout_edge_rsp: got %h len %0d required %h len %0d", got_q[1], acc_len[1], exp_q[1], TO);
      else n_pass++;
      n_checks++;
      if (push_cyc[0] - pop_cyc[0] != TO + 2)
        $display("FAIL timeout_latency: got %0d required %0d", push_cyc[0] - pop_cyc[0], TO + 2);
      else n_pass++;
    end
    n_checks++;
    if (to_pulses != 1)
      $display("FAIL timeout_pulses: got %0d required 1", to_pulses);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bit hung;
    clear_obs();
    cmd_q.push_back(rand_txn(0));
    cmd_q.push_back(rand_txn(1));
    full_remaining = 10;
    run(100, 1'b0, hung);
    n_checks++;
    if (hung || got_q.size() != 2)
      $display("FAIL bp_count: hung=%0d got %0d responses required 2", hung, got_q.size());
    else n_pass++;
    n_checks++;
    if (stall_viol != 0 || full_remaining != 0)
      $display("FAIL bp_stall: %0d active cycles while full, %0d full cycles unused, required 0/0", stall_viol, full_remaining);
    else n_pass++;
    if (got_q.size() == 2) begin
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i])
          $display("FAIL bp_rsp%0d: got %h required %h", i, got_q[i], exp_q[i]);
        else n_pass++;
      end
      n_checks++;
      if (pop_cyc[1] - pop_cyc[0] != 14 || push_cyc[0] - pop_cyc[0] != 13)
        $display("FAIL bp_timing: pop gap %0d push lat %0d required 14/13",
                 pop_cyc[1] - pop_cyc[0], push_cyc[0] - pop_cyc[0]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_access();
    bit hung;
    clear_obs();
    cmd_q.push_back(rand_txn(6));
    cmd_q.push_back(rand_txn(0));
    run(50, 1'b1, hung);
    n_checks++;
    if (hung)
      $display("FAIL rma_reach: ACCESS not reached within budget");
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({psel, penable, pwrite, busy, timeout_err, cmd_rd, rsp_wr} !== 7'b0 ||
        {paddr, pwdata, rsp_data} !== '0)
      $display("FAIL rma_outputs: ctrl %b data %h required all 0",
               {psel, penable, pwrite, busy, timeout_err, cmd_rd, rsp_wr}, {paddr, pwdata, rsp_data});
    else n_pass++;
    // The popped command is lost: forget its expected response.
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    was_access = 1'b0;
    cmd_empty = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run(100, 1'b0, hung);
    n_checks++;
    if (hung || got_q.size() != 1 || exp_q.size() != 1)
      $display("FAIL rma_count: hung=%0d got %0d responses required 1", hung, got_q.size());
    else n_pass++;
    if (got_q.size() == 1 && exp_q.size() == 1 && pop_cyc.size() == 2) begin
      n_checks++;
      if (got_q[0] !== exp_q[0] || push_cyc[0] - pop_cyc[1] != 3)
        $display("FAIL rma_next: got %h lat %0d required %h lat 3",
                 got_q[0], push_cyc[0] - pop_cyc[1], exp_q[0]);
      else n_pass++;
    end
  endtask

  task automatic test_stream();
    bit hung;
    clear_obs();
    for (int i = 0; i < 8; i++) cmd_q.push_back(rand_txn(0));
    run(100, 1'b0, hung);
    n_checks++;
    if (hung || got_q.size() != 8)
      $display("FAIL stream_count: hung=%0d got %0d responses required 8", hung, got_q.size());
    else n_pass++;
    if (got_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i] || push_cyc[i] - pop_cyc[i] != 3)
          $display("FAIL stream_rsp%0d: got %h lat %0d required %h lat 3",
                   i, got_q[i], push_cyc[i] - pop_cyc[i], exp_q[i]);
        else n_pass++;
      end
      for (int i = 1; i < 8; i++) begin
        n_checks++;
        if (pop_cyc[i] - pop_cyc[i-1] != 4)
          $display("FAIL stream_gap%0d: got %0d required 4", i, pop_cyc[i] - pop_cyc[i-1]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    bit   hung;
    txn_t sent[$];
    int   exp_to;
    int   r;
    clear_obs();
    exp_to = 0;
    for (int i = 0; i < 12; i++) begin
      txn_t t;
      r = int'($urandom_range(0, 9));
      if (r < 6)      t = rand_txn(int'($urandom_range(0, 4)));
      else if (r < 8) t = rand_txn(int'($urandom_range(TO - 2, TO)));
      else            t = rand_txn(40);
      if (t.waits >= TO) exp_to++;
      sent.push_back(t);
      cmd_q.push_back(t);
    end
    full_remaining = int'($urandom_range(1, 5));
    run(1000, 1'b0, hung);
    n_checks++;
    if (hung || got_q.size() != 12 || acc_len.size() != 12)
      $display("FAIL rand_count: hung=%0d got %0d responses required 12", hung, got_q.size());
    else n_pass++;
    if (got_q.size() == 12 && acc_len.size() == 12) begin
      for (int i = 0; i < 12; i++) begin
        n_checks++;
        if (got_q[i] !== ref_rsp(sent[i]) || acc_len[i] != ref_acc_len(sent[i]))
          $display("FAIL rand_rsp%0d: got %h len %0d required %h len %0d",
                   i, got_q[i], acc_len[i], ref_rsp(sent[i]), ref_acc_len(sent[i]));
        else n_pass++;
      end
    end
    n_checks++;
    if (to_pulses != exp_to || stable_err != 0)
      $display("FAIL rand_misc: timeouts %0d unstable %0d required %0d/0", to_pulses, stable_err, exp_to);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; acc_cnt = 0; was_access = 1'b0;
    cur = mk_txn(1'b0, '0, '0, 0, '0, 1'b0);
    rst = 1'b1; cmd_empty = 1'b1; cmd_data = '0; rsp_full = 1'b0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    clear_obs();
    test_reset();
    test_single_read();
    test_write_waits();
    test_timeout();
    test_backpressure();
    test_reset_mid_access();
    test_stream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
